// File: rtl/mips_mc_control_if.sv
// Datapath-facing bundle between the multi-cycle sequencer and the
// regfile/ALU/IMem/DMem datapath.
interface mips_mc_control_if #(
  parameter int PC_W = 8
);
  logic [31:0]     instr;
  logic            alu_zero;
  logic [1:0]      alu_addr;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic            reg_dst;
  logic            alu_src;
  logic [3:0]      alu_op;
  logic            mem_to_reg;
  logic            reg_wr;
  logic [3:0]      dmem_wr;

  // Control side: consumes IMem data and ALU flags, drives selects/strobes.
  modport master (
    input  instr, alu_zero, alu_addr,
    output pc, ir, reg_dst, alu_src, alu_op, mem_to_reg, reg_wr, dmem_wr
  );

  // Datapath side.
  modport slave (
    output instr, alu_zero, alu_addr,
    input  pc, ir, reg_dst, alu_src, alu_op, mem_to_reg, reg_wr, dmem_wr
  );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control sequencer: owns PC and IR, steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects/strobes.
module mips_mc_control #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  mips_mc_control_if.master dp,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_BAD, CL_R, CL_I, CL_LW, CL_SW, CL_SB, CL_BEQ, CL_BNE, CL_J
  } cls_e;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_AND = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  cls_e            cls_ir;
  logic            retire;

  // Instruction class; R-type requires a zero shamt field.
  function automatic cls_e classify(input logic [31:0] w);
    classify = CL_BAD;
    case (w[31:26])
      6'b000000: begin
        if (w[10:6] == 5'd0) begin
          case (w[5:0])
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b101010: classify = CL_R;
            default: classify = CL_BAD;
          endcase
        end
      end
      6'b001000, 6'b001001, 6'b001100, 6'b001101: classify = CL_I;
      6'b100011: classify = CL_LW;
      6'b101011: classify = CL_SW;
      6'b101000: classify = CL_SB;
      6'b000100: classify = CL_BEQ;
      6'b000101: classify = CL_BNE;
      6'b000010: classify = CL_J;
      default:   classify = CL_BAD;
    endcase
  endfunction

  // ALU operation for an instruction word (add for memory ops and jumps).
  function automatic logic [3:0] alu_of(input logic [31:0] w);
    alu_of = OP_ADD;
    case (w[31:26])
      6'b000000: begin
        case (w[5:0])
          6'b100010, 6'b100011: alu_of = OP_SUB;
          6'b100100:            alu_of = OP_AND;
          6'b100101:            alu_of = OP_OR;
          6'b100110:            alu_of = OP_XOR;
          6'b101010:            alu_of = OP_SLT;
          default:              alu_of = OP_ADD;
        endcase
      end
      6'b001100:            alu_of = OP_AND;
      6'b001101:            alu_of = OP_OR;
      6'b000100, 6'b000101: alu_of = OP_SUB;
      default:              alu_of = OP_ADD;
    endcase
  endfunction

  assign cls_ir = classify(ir_q);

  // Architectural state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Next-state, PC update and retirement.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: if (en) state_d = S_DECODE;
      S_DECODE: begin
        ir_d = dp.instr;
        if (classify(dp.instr) == CL_BAD) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_ir)
          CL_R, CL_I:         state_d = S_WB;
          CL_LW, CL_SW, CL_SB: state_d = S_MEM;
          CL_BEQ, CL_BNE: begin
            state_d = S_FETCH;
            retire  = 1'b1;
            if ((cls_ir == CL_BEQ) == dp.alu_zero)
              pc_d = pc_q + PC_W'(4) + PC_W'({ir_q[15:0], 2'b00});
            else
              pc_d = pc_q + PC_W'(4);
          end
          CL_J: begin
            state_d = S_FETCH;
            retire  = 1'b1;
            pc_d    = {ir_q[PC_W-3:0], 2'b00};
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (cls_ir == CL_LW) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
          pc_d    = pc_q + PC_W'(4);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
        pc_d    = pc_q + PC_W'(4);
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  // Moore datapath controls; write strobes are also masked while nrst is low
  // so no write escapes in the cycle that reset is being applied.
  always_comb begin
    dp.reg_dst    = 1'b0;
    dp.alu_src    = 1'b0;
    dp.alu_op     = OP_ADD;
    dp.mem_to_reg = 1'b0;
    dp.reg_wr     = 1'b0;
    dp.dmem_wr    = 4'b0000;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      dp.reg_dst = (cls_ir == CL_R);
      dp.alu_src = (cls_ir == CL_I) || (cls_ir == CL_LW) ||
                   (cls_ir == CL_SW) || (cls_ir == CL_SB);
      dp.alu_op  = alu_of(ir_q);
    end
    if (state_q == S_WB) begin
      dp.mem_to_reg = (cls_ir == CL_LW);
      dp.reg_wr     = nrst && ((cls_ir == CL_R) ? (ir_q[15:11] != 5'd0)
                                                : (ir_q[20:16] != 5'd0));
    end
    if (state_q == S_MEM && nrst) begin
      if (cls_ir == CL_SW)      dp.dmem_wr = 4'b1111;
      else if (cls_ir == CL_SB) dp.dmem_wr = 4'b0001 << dp.alu_addr;
    end
  end

  assign dp.pc   = pc_q;
  assign dp.ir   = ir_q;
  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
